maf_issue_ctrl: RTL

- Issue controller for the multi-precision MAF pipeline: arbitrates two operand requesters, drives the per-operation precision code (cont) into the pipeline head, and tracks every in-flight operation to the pipeline tail.
- Enforces a one-cycle bubble on precision-mode change, credit-based flow control toward the result buffer, and a drain/flush sequence.
- Sits between the operand-fetch front end and stage T1; its done_* outputs are aligned with the final stage result.

---
 rtl/maf_issue_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/maf_issue_ctrl.sv
// rtl/maf_issue_ctrl.sv - MAF pipeline issue controller: arbitration, mode bubble, credits, in-flight tracking
module maf_issue_ctrl #(
  parameter int PIPE_LAT = 4,
  parameter int TAG_W    = 4,
  parameter int CREDITS  = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req0_valid,
  input  logic [2:0]       req0_mode,
  input  logic [TAG_W-1:0] req0_tag,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [2:0]       req1_mode,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             req1_ready,
  input  logic             cred_ret,
  input  logic             flush,
  output logic             issue_valid,
  output logic [2:0]       issue_cont,
  output logic             issue_src,
  output logic [TAG_W-1:0] issue_tag,
  output logic             done_valid,
  output logic [2:0]       done_cont,
  output logic             done_src,
  output logic [TAG_W-1:0] done_tag,
  output logic             flush_done,
  output logic             err_illegal,
  output logic             err_cred,
  output logic [3:0]       inflight
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_BUBBLE = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [3:0] CRED_MAX  = 4'(CREDITS);

  logic [1:0]       state;
  logic [3:0]       credits;
  logic [2:0]       last_mode;
  logic             rr;
  logic [3:0]       inflight_q;

  logic             win_src;
  logic             win_valid;
  logic [2:0]       win_mode;
  logic [TAG_W-1:0] win_tag;
  logic             open;
  logic             mode_legal;
  logic             acc_legal;
  logic             acc_illegal;
  logic             mode_chg;
  logic             cred_ok;

  // Tail tracking: one slot per pipeline cycle, fed from the registered issue fields
  logic [PIPE_LAT-1:0]            pipe_v;
  logic [PIPE_LAT-1:0][2:0]       pipe_cont;
  logic [PIPE_LAT-1:0]            pipe_src;
  logic [PIPE_LAT-1:0][TAG_W-1:0] pipe_tag;

  // Round-robin winner: the requester at the pointer, else the other one
  always_comb begin
    win_src = rr;
    if (rr ? !req1_valid : !req0_valid) win_src = ~rr;
    win_valid = win_src ? req1_valid : req0_valid;
    win_mode  = win_src ? req1_mode  : req0_mode;
    win_tag   = win_src ? req1_tag   : req0_tag;
  end

  // Illegal modes are swallowed without needing credits or a matching mode
  assign open        = win_valid && (state == ST_RUN) && !flush;
  assign mode_legal  = (win_mode <= 3'b010);
  assign acc_illegal = open && !mode_legal;
  assign acc_legal   = open && mode_legal && (win_mode == last_mode) && (credits != 4'd0);
  assign mode_chg    = open && mode_legal && (win_mode != last_mode);
  assign cred_ok     = cred_ret && (credits != CRED_MAX);

  assign req0_ready  = (acc_legal || acc_illegal) && !win_src;
  assign req1_ready  = (acc_legal || acc_illegal) &&  win_src;

  assign done_valid  = pipe_v[PIPE_LAT-1];
  assign done_cont   = pipe_cont[PIPE_LAT-1];
  assign done_src    = pipe_src[PIPE_LAT-1];
  assign done_tag    = pipe_tag[PIPE_LAT-1];
  assign inflight    = inflight_q;
  assign flush_done  = flush && (inflight_q == 4'd0) && !issue_valid;

  // Control FSM, arbitration pointer and last issued precision mode
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_RUN;
      rr        <= 1'b0;
      last_mode <= 3'b000;
    end else begin
      case (state)
        ST_RUN:    state <= mode_chg ? ST_BUBBLE : (flush ? ST_DRAIN : ST_RUN);
        ST_BUBBLE: state <= flush ? ST_DRAIN : ST_RUN;
        default:   state <= flush ? ST_DRAIN : ST_RUN;
      endcase
      if (acc_legal || acc_illegal) rr <= ~win_src;
      if (mode_chg) last_mode <= win_mode;
    end
  end

  // Registered issue to the pipeline head plus error pulses
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      issue_valid <= 1'b0;
      issue_cont  <= 3'b000;
      issue_src   <= 1'b0;
      issue_tag   <= '0;
      err_illegal <= 1'b0;
      err_cred    <= 1'b0;
    end else begin
      issue_valid <= acc_legal;
      if (acc_legal) begin
        issue_cont <= win_mode;
        issue_src  <= win_src;
        issue_tag  <= win_tag;
      end
      err_illegal <= acc_illegal;
      err_cred    <= cred_ret && (credits == CRED_MAX);
    end
  end

  // Result-buffer credits and in-flight count
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      credits    <= CRED_MAX;
      inflight_q <= 4'd0;
    end else begin
      if (acc_legal && !cred_ok)      credits <= credits - 4'd1;
      else if (!acc_legal && cred_ok) credits <= credits + 4'd1;
      if (issue_valid && !done_valid)      inflight_q <= inflight_q + 4'd1;
      else if (!issue_valid && done_valid) inflight_q <= inflight_q - 4'd1;
    end
  end

  // Shift the issued operation down the tracking pipe toward the tail
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pipe_v    <= '0;
      pipe_cont <= '0;
      pipe_src  <= '0;
      pipe_tag  <= '0;
    end else begin
      pipe_v    <= {pipe_v[PIPE_LAT-2:0], issue_valid};
      pipe_cont <= {pipe_cont[PIPE_LAT-2:0], issue_cont};
      pipe_src  <= {pipe_src[PIPE_LAT-2:0], issue_src};
      pipe_tag  <= {pipe_tag[PIPE_LAT-2:0], issue_tag};
    end
  end

endmodule
